// File: rtl/ssb_sideband_combiner.sv
// SSB combiner: re-pairs in-phase and quadrature samples through per-path FIFOs,
// forms I - Q (USB) or I + Q (LSB), then saturates or wraps into a ready/valid output.
module ssb_sideband_combiner #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int SAT_EN     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_sample,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] q_sample,
    input  logic              q_valid,
    input  logic              sideband,
    input  logic              out_ready,
    input  logic              clr_stats,
    output logic [DATA_W-1:0] out_sample,
    output logic              out_valid,
    output logic              overflow,
    output logic [15:0]       sat_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Output handshake: out_sample is transferred on a rising edge where
    // out_valid && out_ready; while out_valid is high and out_ready is low,
    // out_sample and out_valid hold unchanged.

    logic [DATA_W-1:0] r_i_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] r_q_mem [FIFO_DEPTH];
    logic [PTR_W:0]    r_i_wr;
    logic [PTR_W:0]    r_i_rd;
    logic [PTR_W:0]    r_q_wr;
    logic [PTR_W:0]    r_q_rd;

    logic signed [DATA_W:0] r_s1_sum;
    logic                   r_s1_valid;
    logic [DATA_W-1:0]      r_out_sample;
    logic                   r_out_valid;
    logic                   r_overflow;
    logic [15:0]            r_sat_count;

    logic w_i_empty;
    logic w_i_full;
    logic w_q_empty;
    logic w_q_full;
    logic w_adv1;
    logic w_adv2;
    logic w_pop;
    logic w_i_push;
    logic w_q_push;
    logic w_ovf_event;
    logic w_sat_event;
    logic w_s1_ovf;

    logic [DATA_W-1:0]      w_i_head;
    logic [DATA_W-1:0]      w_q_head;
    logic signed [DATA_W:0] w_i_ext;
    logic signed [DATA_W:0] w_q_ext;
    logic signed [DATA_W:0] w_sum;
    logic [DATA_W-1:0]      w_result;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_i_empty = (r_i_wr == r_i_rd);
    assign w_q_empty = (r_q_wr == r_q_rd);
    assign w_i_full  = (r_i_wr[PTR_W] != r_i_rd[PTR_W]) &&
                       (r_i_wr[PTR_W-1:0] == r_i_rd[PTR_W-1:0]);
    assign w_q_full  = (r_q_wr[PTR_W] != r_q_rd[PTR_W]) &&
                       (r_q_wr[PTR_W-1:0] == r_q_rd[PTR_W-1:0]);

    assign w_adv2 = !r_out_valid || out_ready;
    assign w_adv1 = !r_s1_valid || w_adv2;
    assign w_pop  = !w_i_empty && !w_q_empty && w_adv1;

    // A pop frees a slot this edge, so a push into a full FIFO is accepted then.
    assign w_i_push    = i_valid && (!w_i_full || w_pop);
    assign w_q_push    = q_valid && (!w_q_full || w_pop);
    assign w_ovf_event = (i_valid && !w_i_push) || (q_valid && !w_q_push);

    assign w_i_head = r_i_mem[r_i_rd[PTR_W-1:0]];
    assign w_q_head = r_q_mem[r_q_rd[PTR_W-1:0]];
    assign w_i_ext  = {w_i_head[DATA_W-1], w_i_head};
    assign w_q_ext  = {w_q_head[DATA_W-1], w_q_head};
    assign w_sum    = sideband ? (w_i_ext + w_q_ext) : (w_i_ext - w_q_ext);

    assign w_s1_ovf    = (r_s1_sum[DATA_W] != r_s1_sum[DATA_W-1]);
    assign w_sat_event = w_adv2 && r_s1_valid && w_s1_ovf;

    always_comb begin
        w_result = r_s1_sum[DATA_W-1:0];
        if (w_s1_ovf && (SAT_EN != 0)) begin
            w_result = r_s1_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                        : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (w_i_push) begin
            r_i_mem[r_i_wr[PTR_W-1:0]] <= i_sample;
        end
        if (w_q_push) begin
            r_q_mem[r_q_wr[PTR_W-1:0]] <= q_sample;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i_wr <= '0;
            r_i_rd <= '0;
            r_q_wr <= '0;
            r_q_rd <= '0;
        end else begin
            if (w_i_push) r_i_wr <= r_i_wr + 1'b1;
            if (w_q_push) r_q_wr <= r_q_wr + 1'b1;
            if (w_pop) begin
                r_i_rd <= r_i_rd + 1'b1;
                r_q_rd <= r_q_rd + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_sum     <= '0;
            r_s1_valid   <= 1'b0;
            r_out_sample <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= w_pop;
                if (w_pop) r_s1_sum <= w_sum;
            end
            if (w_adv2) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) r_out_sample <= w_result;
            end
        end
    end

    // An event in the same cycle as clr_stats survives the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_sat_count <= '0;
        end else if (clr_stats) begin
            r_overflow  <= w_ovf_event;
            r_sat_count <= {15'd0, w_sat_event};
        end else begin
            if (w_ovf_event) r_overflow <= 1'b1;
            if (w_sat_event && (r_sat_count != 16'hFFFF)) r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign out_sample = r_out_sample;
    assign out_valid  = r_out_valid;
    assign overflow   = r_overflow;
    assign sat_count  = r_sat_count;

endmodule

// File: tb/tb_ssb_sideband_combiner.sv
// Bench for ssb_sideband_combiner: saturating and wrapping instances share stimulus;
// a pairing model predicts each output, directed steps cover the corner cases.
module tb_ssb_sideband_combiner;

    localparam int DATA_W = 24;
    localparam int MAX_V  = 8388607;
    localparam int MIN_V  = -8388608;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] i_sample = '0;
    logic              i_valid = 1'b0;
    logic [DATA_W-1:0] q_sample = '0;
    logic              q_valid = 1'b0;
    logic              sideband = 1'b0;
    logic              out_ready = 1'b0;
    logic              clr_stats = 1'b0;

    logic [DATA_W-1:0] out_sample_s, out_sample_w;
    logic              out_valid_s, out_valid_w;
    logic              overflow_s, overflow_w;
    logic [15:0]       sat_count_s, sat_count_w;

    ssb_sideband_combiner #(.DATA_W(DATA_W), .FIFO_DEPTH(4), .SAT_EN(1)) u_dut_sat (
        .clk(clk), .reset(reset),
        .i_sample(i_sample), .i_valid(i_valid),
        .q_sample(q_sample), .q_valid(q_valid),
        .sideband(sideband), .out_ready(out_ready), .clr_stats(clr_stats),
        .out_sample(out_sample_s), .out_valid(out_valid_s),
        .overflow(overflow_s), .sat_count(sat_count_s)
    );

    ssb_sideband_combiner #(.DATA_W(DATA_W), .FIFO_DEPTH(4), .SAT_EN(0)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .i_sample(i_sample), .i_valid(i_valid),
        .q_sample(q_sample), .q_valid(q_valid),
        .sideband(sideband), .out_ready(out_ready), .clr_stats(clr_stats),
        .out_sample(out_sample_w), .out_valid(out_valid_w),
        .overflow(overflow_w), .sat_count(sat_count_w)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_w_q[$];
    logic [DATA_W-1:0] i_pend[$];
    logic [DATA_W-1:0] q_pend[$];
    int n_i_acc = 0;
    int n_q_acc = 0;
    int n_out = 0;
    int sat_exp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Pairs are formed in arrival order; the result is plain integer arithmetic.
    task automatic model_pair();
        int a, b, s;
        logic [31:0] sv;
        while (i_pend.size() > 0 && q_pend.size() > 0) begin
            a = int'($signed(i_pend.pop_front()));
            b = int'($signed(q_pend.pop_front()));
            s = sideband ? a + b : a - b;
            sv = s;
            if (s > MAX_V) begin
                exp_q.push_back(24'h7FFFFF);
                sat_exp++;
            end else if (s < MIN_V) begin
                exp_q.push_back(24'h800000);
                sat_exp++;
            end else begin
                exp_q.push_back(sv[DATA_W-1:0]);
            end
            exp_w_q.push_back(sv[DATA_W-1:0]);
        end
    endtask

    always @(negedge clk) begin
        if (reset && out_valid_s && out_ready) begin
            n_out++;
            check("exp_avail", {31'd0, exp_q.size() > 0}, 32'd1);
            check("valid_match", {31'd0, out_valid_w}, 32'd1);
            if (exp_q.size() > 0) begin
                check("out_sat", {8'd0, out_sample_s}, {8'd0, exp_q.pop_front()});
                check("out_wrap", {8'd0, out_sample_w}, {8'd0, exp_w_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input bit do_i, input logic [DATA_W-1:0] iv,
                        input bit do_q, input logic [DATA_W-1:0] qv, input bit mdl);
        i_valid  = do_i;
        i_sample = iv;
        q_valid  = do_q;
        q_sample = qv;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        q_valid = 1'b0;
        if (mdl) begin
            if (do_i) begin
                i_pend.push_back(iv);
                n_i_acc++;
            end
            if (do_q) begin
                q_pend.push_back(qv);
                n_q_acc++;
            end
            model_pair();
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_w_q.delete();
        i_pend.delete();
        q_pend.delete();
        n_i_acc = 0;
        n_q_acc = 0;
        n_out = 0;
        sat_exp = 0;
    endtask

    task automatic pulse_clr();
        clr_stats = 1'b1;
        idle(1);
        clr_stats = 1'b0;
        sat_exp = 0;
    endtask

    function automatic logic [DATA_W-1:0] rand24();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 3))
            0: r = 32'h007FFFFF - {24'd0, r[7:0]};
            1: r = 32'h00800000 + {24'd0, r[7:0]};
            default: ;
        endcase
        return r[DATA_W-1:0];
    endfunction

    task automatic drain(input string tag);
        int t;
        out_ready = 1'b1;
        idle(8);
        while (i_pend.size() > 0) push(1'b0, '0, 1'b1, rand24(), 1'b1);
        while (q_pend.size() > 0) push(1'b1, rand24(), 1'b0, '0, 1'b1);
        t = 0;
        while ((exp_q.size() > 0 || out_valid_s) && t < 200) begin
            idle(1);
            t++;
        end
        check(tag, {31'd0, t < 200}, 32'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n0;
        bit do_i, do_q;

        idle(3);
        check("rst_valid", {31'd0, out_valid_s}, 32'd0);
        check("rst_sample", {8'd0, out_sample_s}, 32'd0);
        check("rst_ovf", {31'd0, overflow_s}, 32'd0);
        check("rst_satcnt", {16'd0, sat_count_s}, 32'd0);
        reset = 1'b1;
        idle(2);

        // Pairing across unequal arrival times
        out_ready = 1'b1;
        sideband  = 1'b0;
        push(1'b1, 24'd100, 1'b0, '0, 1'b1);
        idle(2);
        check("pair_wait", {31'd0, out_valid_s}, 32'd0);
        push(1'b0, '0, 1'b1, 24'd40, 1'b1);
        check("lat_e0", {31'd0, out_valid_s}, 32'd0);
        idle(1);
        check("lat_e1", {31'd0, out_valid_s}, 32'd0);
        idle(1);
        check("lat_e2", {31'd0, out_valid_s}, 32'd1);
        check("pair_val", {8'd0, out_sample_s}, 32'd60);
        idle(3);
        check("pair_once", n_out, 1);
        check("pair_idle", {31'd0, out_valid_s}, 32'd0);

        // LSB with clamp / wrap
        pulse_clr();
        sideband = 1'b1;
        push(1'b1, 24'h7FFFF0, 1'b1, 24'h000020, 1'b1);
        idle(2);
        check("lsb_sat", {8'd0, out_sample_s}, 32'h7FFFFF);
        check("lsb_wrap", {8'd0, out_sample_w}, 32'h800010);
        idle(2);
        check("lsb_cnt_s", {16'd0, sat_count_s}, 32'd1);
        check("lsb_cnt_w", {16'd0, sat_count_w}, 32'd1);

        // Backpressure: six pairs held, seventh dropped
        sideband  = 1'b0;
        out_ready = 1'b0;
        for (int k = 1; k <= 7; k++) push(1'b1, 24'(k * 1000), 1'b1, 24'(k), k < 7);
        idle(2);
        check("bp_ovf", {31'd0, overflow_s}, 32'd1);
        check("bp_valid", {31'd0, out_valid_s}, 32'd1);
        check("bp_hold", {8'd0, out_sample_s}, 32'd999);
        check("bp_queued", exp_q.size(), 6);
        n0 = n_out;
        drain("bp_drain");
        check("bp_count", n_out - n0, 6);
        pulse_clr();
        check("bp_clr", {31'd0, overflow_s}, 32'd0);

        // Full FIFOs with simultaneous push and pop
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) push(1'b1, 24'(k * 7), 1'b1, 24'(k * 3), 1'b1);
        idle(2);
        n0 = n_out;
        out_ready = 1'b1;
        push(1'b1, 24'd500, 1'b1, 24'd200, 1'b1);
        check("pp_ovf", {31'd0, overflow_s}, 32'd0);
        drain("pp_drain");
        check("pp_count", n_out - n0, 7);
        check("pp_ovf_end", {31'd0, overflow_w}, 32'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) push(1'b1, 24'(k), 1'b1, 24'(k), 1'b1);
        idle(2);
        check("mr_pre", {31'd0, out_valid_s}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mr_async", {31'd0, out_valid_s}, 32'd0);
        clear_model();
        idle(2);
        reset = 1'b1;
        out_ready = 1'b1;
        idle(3);
        check("mr_flushed", {31'd0, out_valid_s}, 32'd0);
        check("mr_satcnt", {16'd0, sat_count_s}, 32'd0);
        push(1'b1, 24'd5, 1'b1, 24'hFFFFFB, 1'b1);
        idle(2);
        check("mr_val", {8'd0, out_sample_s}, 32'd10);
        idle(2);
        check("mr_count", n_out, 1);

        // Stats clear, then event-wins-over-clear
        pulse_clr();
        for (int k = 0; k < 3; k++) push(1'b1, 24'h7FFFFF, 1'b1, 24'h800000, 1'b1);
        idle(4);
        check("st_sat3", {16'd0, sat_count_s}, 32'd3);
        out_ready = 1'b0;
        for (int k = 1; k <= 7; k++) push(1'b1, 24'(k), 1'b1, 24'(k), k < 7);
        idle(2);
        check("st_ovf1", {31'd0, overflow_s}, 32'd1);
        pulse_clr();
        check("st_ovf_clr", {31'd0, overflow_s}, 32'd0);
        check("st_sat_clr", {16'd0, sat_count_s}, 32'd0);
        check("st_sat_clr_w", {16'd0, sat_count_w}, 32'd0);
        clr_stats = 1'b1;
        push(1'b1, 24'd9, 1'b1, 24'd9, 1'b0);
        clr_stats = 1'b0;
        check("st_win", {31'd0, overflow_s}, 32'd1);
        drain("st_drain");
        check("st_sat_end", {16'd0, sat_count_s}, 32'(sat_exp));
        pulse_clr();

        // Randomized traffic; sideband changes only while drained
        for (int seg = 0; seg < 4; seg++) begin
            sideband = seg[0];
            for (int c = 0; c < 150; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                do_i = ($urandom_range(0, 1) == 1) && (n_i_acc - n_out < 4);
                do_q = ($urandom_range(0, 1) == 1) && (n_q_acc - n_out < 4);
                push(do_i, rand24(), do_q, rand24(), 1'b1);
            end
            drain("rnd_drain");
            check("rnd_ovf_s", {31'd0, overflow_s}, 32'd0);
            check("rnd_ovf_w", {31'd0, overflow_w}, 32'd0);
            check("rnd_sat_s", {16'd0, sat_count_s}, 32'(sat_exp));
            check("rnd_sat_w", {16'd0, sat_count_w}, 32'(sat_exp));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
